// File: rtl/simon_fsm.sv
//==============================================================================
// Module      : simon_fsm
// Description : Main controller for the Simon Says game. Runs the two-key
//               start handshake, grows the colour sequence one entry per
//               round, plays it back paced by the timer pulse, checks each
//               player entry against the comparator result and runs the
//               win / fail endings.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clk            in   system clock, all state on rising edge
//   reset          in   asynchronous active-low reset
//   launch_keys    in   [1:0] KEY1 = bit 0, KEY2 = bit 1, 1 = pressed
//   player_input   in   [3:0] colour switches, 0 = idle
//   current_round  out  [5:0] round number for the display
//   pulse          in   one-cycle timer strobe
//   result         in   1 = player_input matches pattern[clr_idx]
//   clr_idx        out  [5:0] pattern memory index
//   add_clr        out  one-cycle request to append a random colour
//   show_clr       out  drive colour LED for pattern[clr_idx]
//   check_round    out  high while waiting for player input
//   speed_up       out  one-cycle timer speed-increase request
//   fail           out  fail LEDs on
//   win            out  game won, held in END
//   game_over      out  high in END
// Build option:
//   SPEED_UP_EN    when defined, speed_up pulses every SPEED_STEP rounds;
//                  otherwise speed_up is tied low and playback rate is fixed.
//==============================================================================
`default_nettype none

module simon_fsm #(
  parameter int MAX_ROUND   = 63,
  parameter int SPEED_STEP  = 5,
  parameter int FAIL_BLINKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] launch_keys,
  input  logic [3:0] player_input,
  output logic [5:0] current_round,
  input  logic       pulse,
  input  logic       result,
  output logic [5:0] clr_idx,
  output logic       add_clr,
  output logic       show_clr,
  output logic       check_round,
  output logic       speed_up,
  output logic       fail,
  output logic       win,
  output logic       game_over
);

  // Elaboration-time parameter sanity checks.
  if (MAX_ROUND < 1 || MAX_ROUND > 63) begin : g_chk_max_round
    $error("simon_fsm: MAX_ROUND must be in 1..63");
  end
  if (SPEED_STEP < 1) begin : g_chk_speed_step
    $error("simon_fsm: SPEED_STEP must be at least 1");
  end
  if (FAIL_BLINKS < 1 || FAIL_BLINKS > 255) begin : g_chk_fail_blinks
    $error("simon_fsm: FAIL_BLINKS must be in 1..255");
  end

  typedef enum logic [3:0] {
    S_READY1        = 4'd0,
    S_READY2        = 4'd1,
    S_READY3        = 4'd2,
    S_READY4        = 4'd3,
    S_ADD_CLR       = 4'd4,
    S_IS_NEXT_PULSE = 4'd5,
    S_PULSE_ON      = 4'd6,
    S_PLAYER_TURN   = 4'd7,
    S_GOOD_TURN     = 4'd8,
    S_DESELECT      = 4'd9,
    S_FAIL_ON_WAIT  = 4'd10,
    S_FAIL_OFF_WAIT = 4'd11,
    S_FAIL_OFF      = 4'd12,
    S_END           = 4'd13
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] current_round_q, current_round_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] fail_cnt_q, fail_cnt_d;
  logic       win_q, win_d;

  logic [5:0] clr_idx_q, clr_idx_d;
  logic       add_clr_q, add_clr_d;
  logic       show_clr_q, show_clr_d;
  logic       check_round_q, check_round_d;
  logic       speed_up_q, speed_up_d;
  logic       fail_q, fail_d;
  logic       game_over_q, game_over_d;

  always_comb begin
    state_d         = state_q;
    current_round_d = current_round_q;
    idx_d           = idx_q;
    fail_cnt_d      = fail_cnt_q;
    win_d           = win_q;

    case (state_q)
      S_READY1: if (launch_keys[0])        state_d = S_READY2;
      S_READY2: if (launch_keys == 2'b00)  state_d = S_READY3;
      S_READY3: if (launch_keys == 2'b11)  state_d = S_READY4;
      S_READY4: if (launch_keys == 2'b00)  state_d = S_ADD_CLR;
      S_ADD_CLR: begin
        current_round_d = current_round_q + 6'd1;
        idx_d           = 6'd0;
        state_d         = S_IS_NEXT_PULSE;
      end
      S_IS_NEXT_PULSE: begin
        if (pulse) begin
          // Whole sequence shown: hand over to the player from entry 0.
          if (idx_q == current_round_q) begin
            state_d = S_PLAYER_TURN;
            idx_d   = 6'd0;
          end else begin
            state_d = S_PULSE_ON;
          end
        end
      end
      S_PULSE_ON: begin
        if (pulse) begin
          idx_d   = idx_q + 6'd1;
          state_d = S_IS_NEXT_PULSE;
        end
      end
      S_PLAYER_TURN: begin
        if (player_input != 4'd0) begin
          if (result) begin
            state_d = S_GOOD_TURN;
          end else begin
            state_d = S_FAIL_ON_WAIT;
            // The failed round does not count; show the last completed one.
            if (current_round_q != 6'd0) current_round_d = current_round_q - 6'd1;
          end
        end
      end
      S_GOOD_TURN: begin
        idx_d   = idx_q + 6'd1;
        state_d = S_DESELECT;
      end
      S_DESELECT: begin
        if (player_input == 4'd0) begin
          if (idx_q == current_round_q) begin
            if (current_round_q == 6'(MAX_ROUND)) begin
              state_d = S_END;
              win_d   = 1'b1;
            end else begin
              state_d = S_ADD_CLR;
            end
          end else begin
            state_d = S_PLAYER_TURN;
          end
        end
      end
      S_FAIL_ON_WAIT:  if (pulse) state_d = S_FAIL_OFF_WAIT;
      S_FAIL_OFF_WAIT: if (pulse) state_d = S_FAIL_OFF;
      S_FAIL_OFF: begin
        fail_cnt_d = fail_cnt_q + 8'd1;
        if (fail_cnt_q == 8'(FAIL_BLINKS - 1)) state_d = S_END;
        else                                   state_d = S_FAIL_ON_WAIT;
      end
      S_END: state_d = S_END;
      default: state_d = S_READY1;
    endcase

    // Outputs are registered, so decode them from the next state to keep
    // them aligned with the state they belong to.
    clr_idx_d     = idx_d;
    add_clr_d     = (state_d == S_ADD_CLR);
    show_clr_d    = (state_d == S_PULSE_ON);
    check_round_d = (state_d == S_PLAYER_TURN);
    fail_d        = (state_d == S_FAIL_ON_WAIT);
    game_over_d   = (state_d == S_END);
`ifdef SPEED_UP_EN
    // current_round_q still holds the old round while ADD_CLR is entered.
    speed_up_d    = (state_d == S_ADD_CLR) && (current_round_q != 6'd0) &&
                    ((int'(current_round_q) % SPEED_STEP) == 0);
`else
    speed_up_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_READY1;
      current_round_q <= 6'd0;
      idx_q           <= 6'd0;
      fail_cnt_q      <= 8'd0;
      win_q           <= 1'b0;
      clr_idx_q       <= 6'd0;
      add_clr_q       <= 1'b0;
      show_clr_q      <= 1'b0;
      check_round_q   <= 1'b0;
      speed_up_q      <= 1'b0;
      fail_q          <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      current_round_q <= current_round_d;
      idx_q           <= idx_d;
      fail_cnt_q      <= fail_cnt_d;
      win_q           <= win_d;
      clr_idx_q       <= clr_idx_d;
      add_clr_q       <= add_clr_d;
      show_clr_q      <= show_clr_d;
      check_round_q   <= check_round_d;
      speed_up_q      <= speed_up_d;
      fail_q          <= fail_d;
      game_over_q     <= game_over_d;
    end
  end

  assign current_round = current_round_q;
  assign clr_idx       = clr_idx_q;
  assign add_clr       = add_clr_q;
  assign show_clr      = show_clr_q;
  assign check_round   = check_round_q;
  assign speed_up      = speed_up_q;
  assign fail          = fail_q;
  assign win           = win_q;
  assign game_over     = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_simon_fsm.sv
//==============================================================================
// Module      : tb_simon_fsm
// Description : Self-checking bench for simon_fsm. Directed game scenarios;
//               expected outputs are queued as each step is driven and
//               compared after the following clock edge.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_simon_fsm;

  localparam int MAX_R = 63;
`ifdef SPEED_UP_EN
  localparam bit SPD_EN = 1'b1;
`else
  localparam bit SPD_EN = 1'b0;
`endif

  // Flag order: {add_clr, show_clr, check_round, speed_up, fail, win, game_over}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_ADD  = 7'b1000000;
  localparam logic [6:0] F_SHOW = 7'b0100000;
  localparam logic [6:0] F_CHK  = 7'b0010000;
  localparam logic [6:0] F_SPD  = 7'b0001000;
  localparam logic [6:0] F_FAIL = 7'b0000100;
  localparam logic [6:0] F_WIN  = 7'b0000010;
  localparam logic [6:0] F_GO   = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] launch_keys = 2'b00;
  logic [3:0] player_input = 4'd0;
  logic       pulse = 1'b0;
  logic       result = 1'b0;
  logic [5:0] current_round;
  logic [5:0] clr_idx;
  logic       add_clr, show_clr, check_round, speed_up, fail, win, game_over;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [6:0] flags;
    logic [5:0] rnd;
    logic [5:0] idx;
  } exp_t;

  exp_t sb[$];

  simon_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .launch_keys  (launch_keys),
    .player_input (player_input),
    .current_round(current_round),
    .pulse        (pulse),
    .result       (result),
    .clr_idx      (clr_idx),
    .add_clr      (add_clr),
    .show_clr     (show_clr),
    .check_round  (check_round),
    .speed_up     (speed_up),
    .fail         (fail),
    .win          (win),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] spd_flag(input int old_round);
    return (SPD_EN && old_round != 0 && (old_round % 5) == 0) ? F_SPD : F_NONE;
  endfunction

  // clr_idx is only defined while showing a colour or checking an entry.
  task automatic check_now();
    exp_t       e;
    logic [6:0] got;
    logic       idx_ok;
    e      = sb.pop_front();
    got    = {add_clr, show_clr, check_round, speed_up, fail, win, game_over};
    idx_ok = !(e.flags[5] || e.flags[4]) || (clr_idx === e.idx);
    checks++;
    assert ((got === e.flags) && (current_round === e.rnd) && idx_ok)
    else begin
      failures++;
      $error("FAIL %s: got flags=%b round=%0d clr_idx=%0d, expected flags=%b round=%0d clr_idx=%0d",
             e.tag, got, current_round, clr_idx, e.flags, e.rnd, e.idx);
    end
  endtask

  task automatic push_exp(input string tag, input logic [6:0] fl,
                          input logic [5:0] rnd, input logic [5:0] idx);
    exp_t e;
    e.tag = tag; e.flags = fl; e.rnd = rnd; e.idx = idx;
    sb.push_back(e);
  endtask

  // Inputs already driven; expectation queued; compared after the edge.
  task automatic step(input string tag, input logic [6:0] fl,
                      input logic [5:0] rnd, input logic [5:0] idx);
    push_exp(tag, fl, rnd, idx);
    @(posedge clk); #1;
    check_now();
  endtask

  task automatic reset_async(input string tag);
    launch_keys = 2'b00; player_input = 4'd0; pulse = 1'b0; result = 1'b0;
    reset = 1'b0;
    #2;
    push_exp(tag, F_NONE, 6'd0, 6'd0);
    check_now();
    step({tag, "_hold"}, F_NONE, 6'd0, 6'd0);
    reset = 1'b1;
    step({tag, "_ready"}, F_NONE, 6'd0, 6'd0);
  endtask

  task automatic handshake();
    launch_keys = 2'b01; step("hs_key1", F_NONE, 6'd0, 6'd0);
    launch_keys = 2'b01; step("hs_key1_hold", F_NONE, 6'd0, 6'd0);
    launch_keys = 2'b00; step("hs_release1", F_NONE, 6'd0, 6'd0);
    launch_keys = 2'b10; step("hs_key2_only", F_NONE, 6'd0, 6'd0);
    launch_keys = 2'b11; step("hs_both", F_NONE, 6'd0, 6'd0);
    launch_keys = 2'b00; step("hs_add_clr", F_ADD, 6'd0, 6'd0);
  endtask

  task automatic start_game();
    handshake();
    launch_keys = 2'b11; // ignored after the handshake
    step("hs_round1", F_NONE, 6'd1, 6'd0);
    launch_keys = 2'b00;
  endtask

  // From IS_NEXT_PULSE with idx 0: show all r colours, end in PLAYER_TURN.
  task automatic playback(input int r);
    logic [5:0] rr;
    rr = 6'(r);
    for (int i = 0; i < r; i++) begin
      pulse = 1'b0; step("pb_wait",     F_NONE, rr, 6'd0);
      pulse = 1'b1; step("pb_show_on",  F_SHOW, rr, 6'(i));
      pulse = 1'b0; step("pb_show_hold", F_SHOW, rr, 6'(i));
      pulse = 1'b1; step("pb_show_off", F_NONE, rr, 6'd0);
    end
    pulse = 1'b1; step("pb_to_player", F_CHK, rr, 6'd0);
    pulse = 1'b0;
  endtask

  task automatic play_round(input int r);
    logic [5:0] rr;
    rr = 6'(r);
    playback(r);
    for (int i = 0; i < r; i++) begin
      player_input = 4'd0; pulse = 1'b1; // pulse is ignored while checking
      step("pl_wait", F_CHK, rr, 6'(i));
      pulse = 1'b0;
      player_input = (i % 7 == 2) ? 4'b0101 : (4'b0001 << (i % 4));
      result = 1'b1;
      step("pl_good_turn", F_NONE, rr, 6'd0);
      result = 1'b0;
      step("pl_deselect_hold", F_NONE, rr, 6'd0);
      player_input = 4'd0;
      if (i < r - 1) begin
        step("pl_next_entry", F_CHK, rr, 6'(i + 1));
      end else if (r == MAX_R) begin
        step("pl_win", F_WIN | F_GO, rr, 6'd0);
      end else begin
        step("pl_add_clr", F_ADD | spd_flag(r), rr, 6'd0);
        step("pl_round_up", F_NONE, rr + 6'd1, 6'd0);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset_state", F_NONE, 6'd0, 6'd0);
    check_now();
    reset = 1'b1;
    step("ready1_idle", F_NONE, 6'd0, 6'd0);

    // Game 0: reset while the add_clr strobe is pending
    handshake();
    reset_async("reset_mid_add");

    // Game 1: rounds 1..5 correct, mistake in round 6, four blinks
    start_game();
    for (int r = 1; r <= 5; r++) play_round(r);
    playback(6);
    player_input = 4'b1000; result = 1'b0;
    step("fail_on", F_FAIL, 6'd5, 6'd0);
    for (int b = 0; b < 4; b++) begin
      pulse = 1'b0; step("fail_on_hold",  F_FAIL, 6'd5, 6'd0);
      pulse = 1'b1; step("fail_off_wait", F_NONE, 6'd5, 6'd0);
      pulse = 1'b0; step("fail_off_hold", F_NONE, 6'd5, 6'd0);
      pulse = 1'b1; step("fail_off",      F_NONE, 6'd5, 6'd0);
      pulse = 1'b0;
      if (b < 3) step("fail_again", F_FAIL, 6'd5, 6'd0);
      else       step("fail_end",   F_GO,   6'd5, 6'd0);
    end
    player_input = 4'd0; launch_keys = 2'b01; pulse = 1'b1;
    step("end_hold_lose", F_GO, 6'd5, 6'd0);
    reset_async("reset_after_fail");

    // Game 2: all rounds correct up to the final one
    start_game();
    for (int r = 1; r <= MAX_R; r++) play_round(r);
    launch_keys = 2'b11; pulse = 1'b1; player_input = 4'b0010; result = 1'b1;
    step("end_hold_win", F_WIN | F_GO, 6'd63, 6'd0);
    reset_async("reset_after_win");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/simon_fsm.md
Name: simon_fsm

Overview:
Main controller for the Simon Says game. It runs the start handshake on two push-keys and grows the colour sequence one entry per round. It plays the sequence back paced by an external timer pulse, checks each player switch entry against a checker result, and runs win and fail endings. It sits between the key/switch inputs and the pattern memory, timer, comparator and LED/display logic. Timer and comparator signals travel in the fsm_sig interface bundle, shown below as sigs.* ports.

Parameters:
MAX_ROUND, 63, final round number; completing it wins. Must fit in 6 bits.
SPEED_STEP, 5, a speed-up is requested every SPEED_STEP rounds.
FAIL_BLINKS, 4, number of fail LED on/off blinks before END.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
launch_keys  in  2  KEY1 is bit 0, KEY2 is bit 1; 1 = pressed
player_input  in  4  colour switches, one-hot when pressed, 0 = idle
current_round  out  6  round number for the display
sigs.pulse  in  1  one-cycle timer strobe
sigs.result  in  1  1 = current player_input matches pattern[clr_idx]
sigs.clr_idx  out  6  pattern memory index for playback or check
sigs.add_clr  out  1  one-cycle request to append a random colour
sigs.show_clr  out  1  drive colour LED for pattern[clr_idx]
sigs.check_round  out  1  high while waiting for player input
sigs.speed_up  out  1  one-cycle timer speed-increase request
sigs.fail  out  1  fail LEDs on
sigs.win  out  1  game won, held in END
sigs.game_over  out  1  high in END

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to READY1; current_round, clr_idx, internal idx and fail_counter are 0; all strobes/flags are 0.
- Start handshake. Each step is one transition and keys are sampled each cycle:
  - READY1: launch_keys[0]=1 -> READY2.
  - READY2: launch_keys=00 -> READY3.
  - READY3: launch_keys=11 -> READY4.
  - READY4: launch_keys=00 -> ADD_CLR.
  - Any other key combination holds the current state.
- ADD_CLR (1 cycle):
  - add_clr=1; current_round <= current_round+1; idx <= 0.
  - speed_up=1 this cycle if the old current_round is a nonzero multiple of SPEED_STEP.
  - -> IS_NEXT_PULSE.
- IS_NEXT_PULSE: hold until pulse. On pulse:
  - if idx==current_round: -> PLAYER_TURN, idx <= 0.
  - otherwise -> PULSE_ON.
- PULSE_ON: show_clr=1, clr_idx=idx. On pulse: idx <= idx+1, -> IS_NEXT_PULSE.
- PLAYER_TURN: check_round=1, clr_idx=idx. When player_input != 0:
  - result=1 -> GOOD_TURN.
  - result=0 -> FAIL_ON_WAIT, and current_round <= current_round-1 (saturate at 0).
- GOOD_TURN (1 cycle): idx <= idx+1, -> DESELECT.
- DESELECT: hold while player_input != 0. When player_input==0:
  - if idx==current_round: current_round==MAX_ROUND -> END with win=1; otherwise -> ADD_CLR.
  - otherwise -> PLAYER_TURN.
- FAIL_ON_WAIT: fail=1. On pulse -> FAIL_OFF_WAIT.
- FAIL_OFF_WAIT: on pulse -> FAIL_OFF.
- FAIL_OFF (1 cycle): fail_counter <= fail_counter+1.
  - if fail_counter==FAIL_BLINKS-1 -> END.
  - otherwise -> FAIL_ON_WAIT, with no further round decrement.
- END: game_over=1; win keeps its value; stays in END until reset.
- Strobes: add_clr and speed_up are asserted for exactly one cycle per ADD_CLR visit.
- Signal sampling and combinations:
  - pulse is ignored in states that do not wait on it.
  - keys are ignored after READY4.
  - A multi-bit player_input counts as a press; its correctness is decided by result.
- Reset mid-game aborts immediately to READY1, with no pending strobes.

Optional Feature:
SPEED_UP_EN. When defined, speed_up is generated as described above. When undefined, speed_up is tied to 0, the multiple-of-SPEED_STEP logic is removed, and playback runs at a fixed rate.

Test Plan:
- Start handshake: KEY1 alone, release, both pressed, release -> one add_clr strobe; current_round=1; state IS_NEXT_PULSE; no speed_up.
- Round 1 playback: two pulses -> show_clr high with clr_idx=0 between the pulses, then check_round=1.
- Correct entry: player_input=0100 with result=1 and held 3 cycles -> GOOD_TURN then hold in DESELECT. Releasing the switch -> ADD_CLR and current_round=2.
- Speed-up: current_round=5 in ADD_CLR -> speed_up=1 for exactly 1 cycle and current_round=6; next round does not repeat the strobe (requires SPEED_UP_EN).
- Mistake at round 6: result=0 on a press -> current_round=5, fail=1. After 4 blink cycles (8 pulses) -> END, game_over=1, win=0.
- Win: current_round=63 and last entry correct -> END with win=1. Asserting reset=0 then -> READY1 with all outputs 0.
